// File: rtl/perceptron_train_ctrl.sv
// Single-layer perceptron training controller: owns the weight file, runs one MAC per
// cycle over samples/dimensions and applies w += (y - act)*x until an error-free epoch.
module perceptron_train_ctrl #(
    parameter int unsigned N_SAMPLES  = 3,
    parameter int unsigned DIM        = 2,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned MAX_EPOCHS = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    output logic [$clog2(N_SAMPLES)-1:0]       smp_idx,
    output logic [$clog2(DIM)-1:0]             dim_idx,
    input  logic signed [DATA_W-1:0]           x_data,
    input  logic                               y_data,
    input  logic                               w_wr_en,
    input  logic [$clog2(DIM)-1:0]             w_wr_idx,
    input  logic signed [DATA_W-1:0]           w_wr_data,
    input  logic [$clog2(DIM)-1:0]             w_rd_idx,
    output logic signed [DATA_W-1:0]           w_rd_data,
    output logic                               busy,
    output logic                               done,
    output logic                               converged,
    output logic                               act_out,
    output logic [$clog2(MAX_EPOCHS+1)-1:0]    epoch_cnt
);

    localparam int unsigned SMP_W  = $clog2(N_SAMPLES);
    localparam int unsigned DIM_W  = $clog2(DIM);
    localparam int unsigned EP_W   = $clog2(MAX_EPOCHS + 1);
    localparam int unsigned ERR_W  = $clog2(N_SAMPLES + 1);
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned ACC_W  = 2 * DATA_W + DIM_W + 1;

    typedef enum logic [2:0] {S_IDLE, S_MAC, S_ACT, S_UPD, S_NEXT, S_DONE} state_e;

    state_e                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [SMP_W-1:0]         smp_q, smp_d;
    logic [DIM_W-1:0]         dim_q, dim_d;
    logic [ERR_W-1:0]         errs_q, errs_d;
    logic [EP_W-1:0]          epoch_q, epoch_d;
    logic                     err_pos_q, err_pos_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     conv_q, conv_d;
    logic                     act_q, act_d;
    logic signed [DATA_W-1:0] w_q [DIM];
    logic signed [DATA_W-1:0] w_d [DIM];

    logic signed [PROD_W-1:0] prod;
    logic [DATA_W:0]          upd_sum;
    logic [DATA_W-1:0]        upd_sat;
    logic                     last_dim;
    logic                     last_smp;
    logic                     acc_pos;

    assign prod     = PROD_W'(x_data) * PROD_W'(w_q[dim_q]);
    assign upd_sum  = err_pos_q ? ({w_q[dim_q][DATA_W-1], w_q[dim_q]} + {x_data[DATA_W-1], x_data})
                                : ({w_q[dim_q][DATA_W-1], w_q[dim_q]} - {x_data[DATA_W-1], x_data});
    assign last_dim = (dim_q == DIM_W'(DIM - 1));
    assign last_smp = (smp_q == SMP_W'(N_SAMPLES - 1));
    assign acc_pos  = !acc_q[ACC_W-1] && (acc_q != '0);

    // Clamp the one-bit-wider update back into the signed weight range
    always_comb begin
        upd_sat = upd_sum[DATA_W-1:0];
        if (upd_sum[DATA_W] != upd_sum[DATA_W-1]) begin
            upd_sat = upd_sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        smp_d     = smp_q;
        dim_d     = dim_q;
        errs_d    = errs_q;
        epoch_d   = epoch_q;
        err_pos_d = err_pos_q;
        conv_d    = conv_q;
        act_d     = act_q;
        w_d       = w_q;

        case (state_q)
            S_IDLE: begin
                if (w_wr_en) begin
                    w_d[w_wr_idx] = w_wr_data;
                end
                if (start) begin
                    state_d = S_MAC;
                    acc_d   = '0;
                    smp_d   = '0;
                    dim_d   = '0;
                    errs_d  = '0;
                    epoch_d = '0;
                    conv_d  = 1'b0;
                end
            end
            S_MAC: begin
                acc_d = acc_q + ACC_W'(prod);
                if (last_dim) begin
                    dim_d   = '0;
                    state_d = S_ACT;
                end else begin
                    dim_d = dim_q + DIM_W'(1);
                end
            end
            S_ACT: begin
                act_d = acc_pos;
                if (y_data != acc_pos) begin
                    errs_d    = errs_q + ERR_W'(1);
                    err_pos_d = y_data;
                    state_d   = S_UPD;
                end else begin
                    state_d = S_NEXT;
                end
            end
            S_UPD: begin
                w_d[dim_q] = upd_sat;
                if (last_dim) begin
                    dim_d   = '0;
                    state_d = S_NEXT;
                end else begin
                    dim_d = dim_q + DIM_W'(1);
                end
            end
            S_NEXT: begin
                acc_d = '0;
                dim_d = '0;
                if (!last_smp) begin
                    smp_d   = smp_q + SMP_W'(1);
                    state_d = S_MAC;
                end else begin
                    epoch_d = epoch_q + EP_W'(1);
                    if (errs_q == '0) begin
                        conv_d  = 1'b1;
                        state_d = S_DONE;
                    end else if (epoch_q == EP_W'(MAX_EPOCHS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        smp_d   = '0;
                        errs_d  = '0;
                        state_d = S_MAC;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            smp_q     <= '0;
            dim_q     <= '0;
            errs_q    <= '0;
            epoch_q   <= '0;
            err_pos_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            conv_q    <= 1'b0;
            act_q     <= 1'b0;
            w_q       <= '{default: '0};
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            smp_q     <= smp_d;
            dim_q     <= dim_d;
            errs_q    <= errs_d;
            epoch_q   <= epoch_d;
            err_pos_q <= err_pos_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            conv_q    <= conv_d;
            act_q     <= act_d;
            w_q       <= w_d;
        end
    end

    assign smp_idx   = smp_q;
    assign dim_idx   = dim_q;
    assign w_rd_data = w_q[w_rd_idx];
    assign busy      = busy_q;
    assign done      = done_q;
    assign converged = conv_q;
    assign act_out   = act_q;
    assign epoch_cnt = epoch_q;

endmodule

// File: tb/tb_perceptron_train_ctrl.sv
// Bench for perceptron_train_ctrl: three instances (epoch limits 16, 2, 1) driven from
// per-instance sample stores, checked against a plain-arithmetic perceptron model.
module tb_perceptron_train_ctrl;

    localparam int NS = 3;
    localparam int D  = 2;

    logic clk;
    logic rst_n;
    logic start_s     [3];
    logic w_wr_en_s   [3];
    logic w_wr_idx_s  [3];
    logic w_rd_idx_s  [3];
    logic signed [7:0] w_wr_data_s [3];
    logic signed [7:0] w_rd_data_s [3];
    logic signed [7:0] x_data_s    [3];
    logic        y_data_s   [3];
    logic [1:0]  smp_idx_s  [3];
    logic        dim_idx_s  [3];
    logic        busy_s     [3];
    logic        done_s     [3];
    logic        conv_s     [3];
    logic        act_s      [3];
    logic [4:0]  epoch_s    [3];

    logic signed [7:0] xs [3][NS][D];
    logic              ys [3][NS];

    int vectors = 0;
    int miscompares = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned ME = (g == 0) ? 16 : ((g == 1) ? 2 : 1);
        logic [$clog2(ME+1)-1:0] ep;
        perceptron_train_ctrl #(
            .N_SAMPLES(3), .DIM(2), .DATA_W(8), .MAX_EPOCHS(ME)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start_s[g]),
            .smp_idx   (smp_idx_s[g]),
            .dim_idx   (dim_idx_s[g]),
            .x_data    (x_data_s[g]),
            .y_data    (y_data_s[g]),
            .w_wr_en   (w_wr_en_s[g]),
            .w_wr_idx  (w_wr_idx_s[g]),
            .w_wr_data (w_wr_data_s[g]),
            .w_rd_idx  (w_rd_idx_s[g]),
            .w_rd_data (w_rd_data_s[g]),
            .busy      (busy_s[g]),
            .done      (done_s[g]),
            .converged (conv_s[g]),
            .act_out   (act_s[g]),
            .epoch_cnt (ep)
        );
        assign epoch_s[g]  = 5'(ep);
        assign x_data_s[g] = xs[g][smp_idx_s[g]][dim_idx_s[g]];
        assign y_data_s[g] = ys[g][smp_idx_s[g]];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int w0; int w1; int epochs; int conv; int act; int cycles;
    } res_t;

    typedef struct {
        int k; int x[6]; int y[3]; int w0; int w1; int mode;
        int ew0; int ew1; int econv; int eep; int ecyc; int eact;
    } vec_t;

    vec_t tbl [4];

    task automatic chk(input string name, input longint actual, input longint expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic int maxe(input int k);
        return (k == 0) ? 16 : ((k == 1) ? 2 : 1);
    endfunction

    function automatic int sat8(input int v);
        return (v > 127) ? 127 : ((v < -128) ? -128 : v);
    endfunction

    // Straightforward perceptron training with cycle accounting per sample
    function automatic res_t model(input int k, input int w0, input int w1, input int maxep);
        res_t r;
        int w[2];
        w[0] = w0; w[1] = w1;
        r.cycles = 0; r.conv = 0; r.epochs = 0; r.act = 0;
        for (int ep = 0; ep < maxep; ep++) begin
            int errs;
            errs = 0;
            for (int s = 0; s < NS; s++) begin
                int acc;
                int a;
                int err;
                acc = 0;
                for (int d = 0; d < D; d++) acc += int'(xs[k][s][d]) * w[d];
                a = (acc > 0) ? 1 : 0;
                r.act = a;
                err = int'(ys[k][s]) - a;
                if (err != 0) begin
                    errs++;
                    r.cycles += 2 * D + 2;
                    for (int d = 0; d < D; d++) w[d] = sat8(w[d] + err * int'(xs[k][s][d]));
                end else begin
                    r.cycles += D + 2;
                end
            end
            r.epochs++;
            if (errs == 0) begin
                r.conv = 1;
                break;
            end
        end
        r.w0 = w[0]; r.w1 = w[1];
        return r;
    endfunction

    task automatic load_data(input int k, input int x[6], input int y[3]);
        for (int s = 0; s < NS; s++) begin
            for (int d = 0; d < D; d++) xs[k][s][d] = 8'(x[s*D+d]);
            ys[k][s] = 1'(y[s]);
        end
    endtask

    task automatic preload(input int k, input int w0, input int w1);
        w_wr_en_s[k] = 1'b1; w_wr_idx_s[k] = 1'b0; w_wr_data_s[k] = 8'(w0);
        @(posedge clk); #1;
        w_wr_idx_s[k] = 1'b1; w_wr_data_s[k] = 8'(w1);
        @(posedge clk); #1;
        w_wr_en_s[k] = 1'b0;
    endtask

    // mode 0: plain run; 1: start + weight write mid-run; 2: start during the DONE cycle
    task automatic run_vec(input int k, input int w0, input int w1, input int mode,
                           input string tag, input res_t exp_r);
        int cyc;
        preload(k, w0, w1);
        start_s[k] = 1'b1;
        @(posedge clk); #1;
        start_s[k] = 1'b0;
        chk({tag, " busy_after_start"}, busy_s[k], 1);
        cyc = 0;
        while (!done_s[k] && cyc < 4000) begin
            @(posedge clk); #1;
            cyc++;
            if (mode == 1 && cyc == 3) begin
                start_s[k] = 1'b1; w_wr_en_s[k] = 1'b1;
                w_wr_idx_s[k] = 1'b0; w_wr_data_s[k] = 8'sh55;
            end
            if (mode == 1 && cyc == 4) begin
                start_s[k] = 1'b0; w_wr_en_s[k] = 1'b0;
            end
        end
        chk({tag, " cycles"}, cyc, exp_r.cycles);
        chk({tag, " busy_in_done"}, busy_s[k], 0);
        chk({tag, " converged"}, conv_s[k], exp_r.conv);
        chk({tag, " epoch_cnt"}, epoch_s[k], exp_r.epochs);
        chk({tag, " act_out"}, act_s[k], exp_r.act);
        w_rd_idx_s[k] = 1'b0; #1;
        chk({tag, " w0"}, w_rd_data_s[k], exp_r.w0);
        w_rd_idx_s[k] = 1'b1; #1;
        chk({tag, " w1"}, w_rd_data_s[k], exp_r.w1);
        if (mode == 2) start_s[k] = 1'b1;
        @(posedge clk); #1;
        start_s[k] = 1'b0;
        chk({tag, " done_one_cycle"}, done_s[k], 0);
        if (mode == 2) begin
            chk({tag, " start_in_done_ignored"}, busy_s[k], 0);
            @(posedge clk); #1;
            chk({tag, " still_idle"}, busy_s[k], 0);
        end
    endtask

    initial begin
        res_t r;
        int x[6];
        int y[3];

        tbl[0] = '{k:0, x:'{2,3,4,5,4,5}, y:'{0,1,1}, w0:3, w1:-2, mode:0,
                   ew0:3, ew1:-2, econv:1, eep:1, ecyc:12, eact:1};
        tbl[1] = '{k:1, x:'{2,3,4,5,4,5}, y:'{0,1,1}, w0:4, w1:9, mode:1,
                   ew0:0, ew1:3, econv:0, eep:2, ecyc:28, eact:1};
        tbl[2] = '{k:2, x:'{1,1,1,1,1,1}, y:'{1,1,1}, w0:127, w1:-128, mode:2,
                   ew0:127, ew1:-126, econv:0, eep:1, ecyc:16, eact:1};
        tbl[3] = '{k:0, x:'{1,1,1,1,1,1}, y:'{1,1,1}, w0:127, w1:-128, mode:0,
                   ew0:127, ew1:-126, econv:1, eep:2, ecyc:28, eact:1};

        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            start_s[k] = 1'b0; w_wr_en_s[k] = 1'b0; w_wr_idx_s[k] = 1'b0;
            w_wr_data_s[k] = '0; w_rd_idx_s[k] = 1'b0;
            for (int s = 0; s < NS; s++) begin
                ys[k][s] = 1'b0;
                for (int d = 0; d < D; d++) xs[k][s][d] = '0;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", busy_s[0], 0);
        chk("rst done", done_s[0], 0);
        chk("rst converged", conv_s[0], 0);
        chk("rst act_out", act_s[0], 0);
        chk("rst epoch_cnt", epoch_s[0], 0);
        chk("rst smp_idx", smp_idx_s[0], 0);
        chk("rst dim_idx", dim_idx_s[0], 0);
        chk("rst w0", w_rd_data_s[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        preload(0, -5, 17);
        w_rd_idx_s[0] = 1'b0; #1;
        chk("preload w0", w_rd_data_s[0], -5);
        w_rd_idx_s[0] = 1'b1; #1;
        chk("preload w1", w_rd_data_s[0], 17);

        // Abort in the first UPD cycle of a run whose first sample misclassifies
        x = '{2,3,4,5,4,5}; y = '{0,1,1};
        load_data(0, x, y);
        preload(0, 4, 9);
        start_s[0] = 1'b1;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midrun busy_before", busy_s[0], 1);
        chk("midrun act_before", act_s[0], 1);
        rst_n = 1'b0;
        #1;
        chk("midrun rst busy", busy_s[0], 0);
        chk("midrun rst done", done_s[0], 0);
        chk("midrun rst converged", conv_s[0], 0);
        chk("midrun rst act_out", act_s[0], 0);
        chk("midrun rst epoch_cnt", epoch_s[0], 0);
        w_rd_idx_s[0] = 1'b0; #1;
        chk("midrun rst w0", w_rd_data_s[0], 0);
        w_rd_idx_s[0] = 1'b1; #1;
        chk("midrun rst w1", w_rd_data_s[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            load_data(tbl[i].k, tbl[i].x, tbl[i].y);
            r.w0 = tbl[i].ew0; r.w1 = tbl[i].ew1; r.conv = tbl[i].econv;
            r.epochs = tbl[i].eep; r.cycles = tbl[i].ecyc; r.act = tbl[i].eact;
            run_vec(tbl[i].k, tbl[i].w0, tbl[i].w1, tbl[i].mode, $sformatf("tbl%0d", i), r);
        end

        for (int it = 0; it < 30; it++) begin
            int k;
            int w0;
            int w1;
            k = it % 3;
            for (int j = 0; j < 6; j++) begin
                if ($urandom_range(0, 3) == 0) x[j] = int'($urandom_range(0, 255)) - 128;
                else x[j] = int'($urandom_range(0, 14)) - 7;
            end
            for (int j = 0; j < 3; j++) y[j] = int'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                w0 = int'($urandom_range(0, 255)) - 128;
                w1 = int'($urandom_range(0, 255)) - 128;
            end else begin
                w0 = int'($urandom_range(0, 40)) - 20;
                w1 = int'($urandom_range(0, 40)) - 20;
            end
            load_data(k, x, y);
            r = model(k, w0, w1, maxe(k));
            run_vec(k, w0, w1, (it % 5 == 0) ? 1 : 0, $sformatf("rnd%0d", it), r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/perceptron_train_ctrl.md
Name: perceptron_train_ctrl

Overview:
- Sequential training controller for the single-layer perceptron.
- Owns the weight register file and steps through samples and dimensions one MAC per cycle.
- Per sample: applies the step activation, then applies the perceptron update w += (y - act)·x. Repeats epochs until an error-free epoch or the epoch limit.
- Sample/label storage is external and read combinationally through an address port. Sits between the tile I/O wrapper and the sample store.

Parameters:
N_SAMPLES, 3, number of training samples per epoch
DIM, 2, input dimension (weights per neuron)
DATA_W, 8, signed width of x and w
MAX_EPOCHS, 16, epoch limit before giving up (>=1)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin training; sampled only in IDLE
smp_idx  output  clog2(N_SAMPLES)  sample address to store
dim_idx  output  clog2(DIM)  dimension address to store
x_data  input  DATA_W  signed x[smp_idx][dim_idx], valid same cycle
y_data  input  1  label of smp_idx (0/1), valid same cycle
w_wr_en  input  1  weight preload strobe; honoured only in IDLE
w_wr_idx  input  clog2(DIM)  preload index
w_wr_data  input  DATA_W  signed preload value
w_rd_idx  input  clog2(DIM)  readback index
w_rd_data  output  DATA_W  combinational readback of w[w_rd_idx]
busy  output  1  high from the cycle after start is accepted until DONE
done  output  1  one-cycle pulse in DONE
converged  output  1  last run ended on an error-free epoch; held until next start
act_out  output  1  last activation computed
epoch_cnt  output  clog2(MAX_EPOCHS+1)  epochs completed in current/last run

Behaviour:
- Reset (async, any state): state=IDLE; all weights, acc, indices, counters and outputs = 0.
- States: IDLE, MAC, ACT, UPD, NEXT, DONE.
- IDLE: start=1 moves to MAC. On that edge: clear acc, smp_idx, dim_idx, epoch error count and epoch_cnt; clear converged. w_wr_en writes w[w_wr_idx] only in IDLE.
- MAC: DIM cycles. Each cycle acc += x_data·w[dim_idx] and dim_idx increments. acc is signed 2·DATA_W+clog2(DIM)+1, so no overflow is possible. After the last dim, dim_idx=0 and state goes to ACT.
- ACT: 1 cycle. act = (acc > 0) ? 1 : 0, registered to act_out. err = y_data - act, in {-1,0,+1}. If err≠0: increment epoch error count, go to UPD. Else go to NEXT.
- UPD: DIM cycles. w[dim_idx] = sat(w + err·x_data), saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- NEXT: 1 cycle; clears acc and dim_idx.
  - Not the last sample: smp_idx++, go to MAC.
  - Last sample: epoch_cnt++. If error count = 0, set converged=1 and go to DONE. Else if epoch_cnt+1 = MAX_EPOCHS, go to DONE with converged=0. Else smp_idx=0, error count=0, go to MAC.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- Timing per sample: DIM+2 cycles without error, 2·DIM+2 with error. No idle cycles between samples or epochs.
- start while busy: ignored. w_wr_en while busy: ignored, and weights are unchanged by it.
- Reset mid-run: immediate abort to IDLE, weights zeroed; no done pulse.
- start and done do not overlap; a start in the DONE cycle is ignored.

Test Plan:
- Convergent: N=3, DIM=2; x=(2,3),(4,5),(4,5), y=0,1,1; preload W=(3,-2); start → no updates. done pulses exactly 12 cycles after the start-accept edge; converged=1, epoch_cnt=1, W=(3,-2), act_out=1.
- Limit: same data, preload W=(4,9), MAX_EPOCHS=2 → epoch1 ends W=(2,6), epoch2 ends W=(0,3); done with converged=0, epoch_cnt=2.
- Saturation: all x=(1,1), y=1; W=(127,-128); MAX_EPOCHS=1 → after the epoch W=(127,-126) with w0 clamped at 127; converged=0.
- Preload/readback: write W0=-5, W1=17 in IDLE → w_rd_data returns -5 and 17. A write attempted while busy leaves weights unchanged.
- Reset mid-run: assert rst_n=0 during UPD → busy, done, converged, act_out, epoch_cnt and all weights read 0 the same cycle. A fresh start then runs normally.
- Start while busy: pulse start mid-epoch → cycle count and final weights identical to the run without the extra pulse.
